// File: rtl/square_draw_pkg.sv
// Shared types and constants for the square draw scheduler and its arbiter.
package square_draw_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDraw = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned SQUARE_SIDE = 4;
  localparam int unsigned CNT_W       = 4;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_X_W      = 8;
  localparam int unsigned DEF_Y_W      = 7;
  localparam int unsigned DEF_COLOUR_W = 3;

  // Count value of the last pixel of a square.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SQUARE_SIDE * SQUARE_SIDE - 1);

endpackage

// File: rtl/square_draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr, with wraparound.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_any,
  output logic [N-1:0]         o_win
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned SW = PW + 1;

  logic [SW-1:0] w_idx;

  always_comb begin
    o_win = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, i_ptr} + SW'(k);
      if (w_idx >= SW'(N)) begin
        w_idx = w_idx - SW'(N);
      end
      if (!o_any && i_req[w_idx[PW-1:0]]) begin
        o_win[w_idx[PW-1:0]] = 1'b1;
        o_any                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_draw_scheduler.sv
// Shares one 4x4 square pixel walker between N_REQ requesters and drives the VGA adapter.
module square_draw_scheduler
  import square_draw_pkg::*;
#(
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned COLOUR_W = DEF_COLOUR_W
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*X_W-1:0]      i_req_x,
  input  logic [N_REQ*Y_W-1:0]      i_req_y,
  input  logic [N_REQ*COLOUR_W-1:0] i_req_colour,
  input  logic [N_REQ-1:0]          i_req_erase,
  output logic [N_REQ-1:0]          o_grant,
  output logic [N_REQ-1:0]          o_done,
  output logic [X_W-1:0]            o_vga_x,
  output logic [Y_W-1:0]            o_vga_y,
  output logic [COLOUR_W-1:0]       o_vga_colour,
  output logic                      o_vga_plot,
  output logic                      o_busy
);

  localparam int unsigned PW = $clog2(N_REQ);

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d, w_cnt_inc;
  logic [PW-1:0]       r_ptr, w_ptr_d;
  logic [PW-1:0]       r_owner, w_owner_d;
  logic [X_W-1:0]      r_base_x, w_base_x_d;
  logic [Y_W-1:0]      r_base_y, w_base_y_d;
  logic [COLOUR_W-1:0] r_colour, w_colour_d;

  logic [N_REQ-1:0]    r_grant, w_grant_d;
  logic [N_REQ-1:0]    r_done, w_done_d;
  logic [X_W-1:0]      r_vga_x, w_vga_x_d;
  logic [Y_W-1:0]      r_vga_y, w_vga_y_d;
  logic [COLOUR_W-1:0] r_vga_colour, w_vga_colour_d;
  logic                r_vga_plot, w_vga_plot_d;
  logic                r_busy, w_busy_d;

  logic                w_any;
  logic [N_REQ-1:0]    w_win;
  logic [PW-1:0]       w_win_idx;
  logic [X_W-1:0]      w_sel_x;
  logic [Y_W-1:0]      w_sel_y;
  logic [COLOUR_W-1:0] w_sel_colour;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_win (w_win)
  );

  // Mux the winner's request fields; erase forces black at the grant edge.
  always_comb begin
    w_win_idx    = '0;
    w_sel_x      = '0;
    w_sel_y      = '0;
    w_sel_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win[i]) begin
        w_win_idx    = PW'(i);
        w_sel_x      = i_req_x[i*X_W +: X_W];
        w_sel_y      = i_req_y[i*Y_W +: Y_W];
        w_sel_colour = i_req_erase[i] ? COLOUR_W'(COLOUR_BLACK)
                                      : i_req_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_ptr_d        = r_ptr;
    w_owner_d      = r_owner;
    w_base_x_d     = r_base_x;
    w_base_y_d     = r_base_y;
    w_colour_d     = r_colour;
    w_grant_d      = '0;
    w_done_d       = '0;
    w_vga_x_d      = r_vga_x;
    w_vga_y_d      = r_vga_y;
    w_vga_colour_d = r_vga_colour;
    w_vga_plot_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_d      = StDraw;
          w_cnt_d        = '0;
          w_owner_d      = w_win_idx;
          w_ptr_d        = (w_win_idx == PW'(N_REQ - 1)) ? '0 : w_win_idx + PW'(1);
          w_base_x_d     = w_sel_x;
          w_base_y_d     = w_sel_y;
          w_colour_d     = w_sel_colour;
          w_grant_d      = w_win;
          w_vga_x_d      = w_sel_x;
          w_vga_y_d      = w_sel_y;
          w_vga_colour_d = w_sel_colour;
          w_vga_plot_d   = 1'b1;
        end
      end
      StDraw: begin
        if (r_cnt == CNT_LAST) begin
          w_state_d = StDone;
          w_done_d  = N_REQ'(1) << r_owner;
        end else begin
          // Row-major walk: low count bits are the x offset, high bits the y offset.
          w_cnt_d      = w_cnt_inc;
          w_vga_x_d    = r_base_x + X_W'(w_cnt_inc[1:0]);
          w_vga_y_d    = r_base_y + Y_W'(w_cnt_inc[3:2]);
          w_vga_plot_d = 1'b1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_colour     <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_ptr        <= w_ptr_d;
      r_owner      <= w_owner_d;
      r_base_x     <= w_base_x_d;
      r_base_y     <= w_base_y_d;
      r_colour     <= w_colour_d;
      r_grant      <= w_grant_d;
      r_done       <= w_done_d;
      r_vga_x      <= w_vga_x_d;
      r_vga_y      <= w_vga_y_d;
      r_vga_colour <= w_vga_colour_d;
      r_vga_plot   <= w_vga_plot_d;
      r_busy       <= w_busy_d;
    end
  end

  assign o_grant      = r_grant;
  assign o_done       = r_done;
  assign o_vga_x      = r_vga_x;
  assign o_vga_y      = r_vga_y;
  assign o_vga_colour = r_vga_colour;
  assign o_vga_plot   = r_vga_plot;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_square_draw_scheduler.sv
// Bench for square_draw_scheduler: directed scenarios plus random traffic vs a timeline model.
module tb_square_draw_scheduler;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req   = '0;
  logic [N-1:0]    erase = '0;
  logic [XW-1:0]   rx[N];
  logic [YW-1:0]   ry[N];
  logic [CW-1:0]   rc[N];
  logic [N*XW-1:0] req_x_p;
  logic [N*YW-1:0] req_y_p;
  logic [N*CW-1:0] req_c_p;

  always_comb begin
    req_x_p = '0;
    req_y_p = '0;
    req_c_p = '0;
    for (int i = 0; i < N; i++) begin
      req_x_p[i*XW +: XW] = rx[i];
      req_y_p[i*YW +: YW] = ry[i];
      req_c_p[i*CW +: CW] = rc[i];
    end
  end

  logic [N-1:0]  grant, done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot, busy;

  square_draw_scheduler #(
    .N_REQ    (N),
    .X_W      (XW),
    .Y_W      (YW),
    .COLOUR_W (CW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_req        (req),
    .i_req_x      (req_x_p),
    .i_req_y      (req_y_p),
    .i_req_colour (req_c_p),
    .i_req_erase  (erase),
    .o_grant      (grant),
    .o_done       (done),
    .o_vga_x      (vga_x),
    .o_vga_y      (vga_y),
    .o_vga_colour (vga_colour),
    .o_vga_plot   (vga_plot),
    .o_busy       (busy)
  );

  // Model: phase = edges since the grant edge (0..15 plot, 16 done), -1 = idle.
  int            phase = -1;
  int            m_ptr = 0;
  int            m_owner = 0;
  logic [XW-1:0] m_bx;
  logic [YW-1:0] m_by;
  logic [CW-1:0] m_c;
  logic [N-1:0]  e_grant, e_done;
  logic          e_plot, e_busy, e_xyc;
  logic [XW-1:0] e_x;
  logic [YW-1:0] e_y;
  logic [CW-1:0] e_c;

  int n_checks = 0;
  int n_pass   = 0;
  int q_order[$];
  bit rand_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    logic [N-1:0] one;
    one   = 1;
    e_xyc = 1'b0;
    if (!resetn) begin
      phase = -1;
      m_ptr = 0;
      e_x   = '0;
      e_y   = '0;
      e_c   = '0;
      e_xyc = 1'b1;
    end else if (phase < 0) begin
      if (req != 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (req[idx]) begin
            m_owner = idx;
            break;
          end
        end
        m_bx  = rx[m_owner];
        m_by  = ry[m_owner];
        m_c   = erase[m_owner] ? '0 : rc[m_owner];
        m_ptr = (m_owner + 1) % N;
        phase = 0;
      end
    end else begin
      phase++;
      if (phase == 17) phase = -1;
    end
    e_grant = (phase == 0)  ? (one << m_owner) : '0;
    e_done  = (phase == 16) ? (one << m_owner) : '0;
    e_plot  = (phase >= 0) && (phase < 16);
    e_busy  = (phase >= 0);
    if (e_plot) begin
      e_x   = m_bx + XW'(phase % 4);
      e_y   = m_by + YW'(phase / 4);
      e_c   = m_c;
      e_xyc = 1'b1;
    end
  endtask

  task automatic compare();
    check("grant", grant, e_grant);
    check("done", done, e_done);
    check("plot", vga_plot, e_plot);
    check("busy", busy, e_busy);
    if (e_xyc) begin
      check("vga_x", vga_x, e_x);
      check("vga_y", vga_y, e_y);
      check("colour", vga_colour, e_c);
    end
    for (int i = 0; i < N; i++) if (grant[i]) q_order.push_back(i);
  endtask

  task automatic rand_stim();
    for (int i = 0; i < N; i++) begin
      if (!req[i]) begin
        rx[i]    = XW'($urandom);
        ry[i]    = YW'($urandom);
        rc[i]    = CW'($urandom);
        erase[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        req[i] = 1'b0;
      end
    end
    resetn = ($urandom_range(0, 299) != 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    for (int i = 0; i < N; i++) if (e_grant[i]) req[i] = 1'b0;
    if (rand_on) rand_stim();
  endtask

  task automatic check_order(input string tag, input int a0, input int a1, input int a2,
                             input int a3);
    int exp_a[4];
    exp_a = '{a0, a1, a2, a3};
    check({tag, "_len"}, q_order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check(tag, (i < q_order.size()) ? q_order[i] : -1, exp_a[i]);
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < N; i++) begin
      rx[i] = '0;
      ry[i] = '0;
      rc[i] = '0;
    end
    step();
    step();
    resetn = 1'b1;
    step();

    // Single draw, then an erase.
    rx[2] = 8'd10; ry[2] = 7'd20; rc[2] = 3'd5; erase[2] = 1'b0; req[2] = 1'b1;
    repeat (20) step();
    rx[0] = 8'd30; ry[0] = 7'd40; rc[0] = 3'd7; erase[0] = 1'b1; req[0] = 1'b1;
    repeat (20) step();
    erase = '0;

    // Round-robin from ptr=0, then from ptr=2.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int i = 0; i < N; i++) begin
      rx[i] = XW'(16 * i); ry[i] = YW'(8 * i); rc[i] = CW'(i + 1);
    end
    q_order.delete();
    req = '1;
    repeat (4 * 18 + 2) step();
    check_order("rr_p0", 0, 1, 2, 3);
    req[1] = 1'b1;
    repeat (19) step();
    q_order.delete();
    req = '1;
    repeat (4 * 18 + 2) step();
    check_order("rr_p2", 2, 3, 0, 1);

    // Coordinate wraparound, then input changes during a draw.
    rx[1] = 8'd254; ry[1] = 7'd126; rc[1] = 3'd3; req[1] = 1'b1;
    repeat (20) step();
    rx[1] = 8'd40; ry[1] = 7'd10; rc[1] = 3'd6; req[1] = 1'b1;
    step();
    rx[1] = 8'd90; ry[1] = 7'd50; rc[1] = 3'd1;
    repeat (19) step();

    // Reset at cnt=7 with req[3] still pending.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    req[0] = 1'b1;
    req[3] = 1'b1;
    guard  = 0;
    do begin
      step();
      guard++;
    end while (phase != 7 && guard < 40);
    check("reach_cnt7", phase, 7);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    check("grant_after_rst", grant, 4'b1000);
    repeat (20) step();

    rand_on = 1'b1;
    repeat (4000) step();
    rand_on = 1'b0;
    resetn  = 1'b1;
    req     = '0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
